// File: rtl/oled_pixel_streamer.sv
// SSD1331 frame streamer: snapshots a 1bpp bitmap and two colours, then emits one colour per pixel as bytes.
// Define OLED_STREAM_WINDOW_EN to prefix each frame with the six address-window command bytes.
module oled_pixel_streamer #(
  parameter int NUM_COL      = 96,
  parameter int NUM_ROW      = 64,
  parameter int N_COLOR_BITS = 8,
  parameter int COL_OFFSET   = 0,
  parameter int ROW_OFFSET   = 0
) (
  input  logic                         i_CLK,
  input  logic                         i_RST,
  input  logic                         i_START,
  input  logic [N_COLOR_BITS-1:0]      i_TEXT_COLOR,
  input  logic [N_COLOR_BITS-1:0]      i_BACKGROUND_COLOR,
  input  logic [NUM_COL*NUM_ROW-1:0]   i_PIXEL,
  input  logic                         i_ACK,
  output logic [7:0]                   o_DATA,
  output logic                         o_DC,
  output logic                         o_VALID,
  output logic                         o_READY,
  output logic                         o_DONE
);

  localparam int NPIX  = NUM_COL * NUM_ROW;
  localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int ROW_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam bit WIDE  = (N_COLOR_BITS == 16);

  if (N_COLOR_BITS != 8 && N_COLOR_BITS != 16) begin : g_bad_depth
    $error("oled_pixel_streamer: N_COLOR_BITS must be 8 or 16");
  end
  if (NUM_COL < 1 || COL_OFFSET < 0 || COL_OFFSET + NUM_COL > 96) begin : g_bad_cols
    $error("oled_pixel_streamer: column window outside the 96-column panel");
  end
  if (NUM_ROW < 1 || ROW_OFFSET < 0 || ROW_OFFSET + NUM_ROW > 64) begin : g_bad_rows
    $error("oled_pixel_streamer: row window outside the 64-row panel");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_PIXEL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state;
  logic [COL_W-1:0]          col_cnt;
  logic [ROW_W-1:0]          row_cnt;
  logic [IDX_W-1:0]          pix_idx;
  logic                      phase;
  logic [NPIX-1:0]           pix_snap;
  logic [N_COLOR_BITS-1:0]   text_snap;
  logic [N_COLOR_BITS-1:0]   bg_snap;

  logic                      last_byte;
  logic                      last_col;
  logic                      last_row;
  logic                      last_phase;
  logic [COL_W-1:0]          nxt_col;
  logic [ROW_W-1:0]          nxt_row;
  logic [IDX_W-1:0]          nxt_idx;
  logic                      nxt_phase;
  logic [7:0]                nxt_byte;

  // Phase 0 carries the MSB byte of a 16-bit colour; 8-bit colours use the low byte only.
  function automatic logic [7:0] color_byte(input logic [N_COLOR_BITS-1:0] color, input logic hi);
    logic [15:0] c16;
    c16 = 16'(color);
    return (WIDE && hi) ? c16[15:8] : c16[7:0];
  endfunction

  function automatic logic [7:0] pixel_byte(input logic                    bit_on,
                                            input logic [N_COLOR_BITS-1:0] text,
                                            input logic [N_COLOR_BITS-1:0] bg,
                                            input logic                    hi);
    return color_byte(bit_on ? text : bg, hi);
  endfunction

`ifdef OLED_STREAM_WINDOW_EN
  localparam logic [7:0] COL_FIRST = 8'(COL_OFFSET);
  localparam logic [7:0] COL_LAST  = 8'(COL_OFFSET + NUM_COL - 1);
  localparam logic [7:0] ROW_FIRST = 8'(ROW_OFFSET);
  localparam logic [7:0] ROW_LAST  = 8'(ROW_OFFSET + NUM_ROW - 1);

  logic [2:0] cmd_cnt;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h15;
      3'd1:    return COL_FIRST;
      3'd2:    return COL_LAST;
      3'd3:    return 8'h75;
      3'd4:    return ROW_FIRST;
      default: return ROW_LAST;
    endcase
  endfunction
`endif

  // Position and byte value of whatever follows the byte currently presented.
  always_comb begin
    last_phase = WIDE ? phase : 1'b1;
    last_col   = (col_cnt == COL_W'(NUM_COL - 1));
    last_row   = (row_cnt == ROW_W'(NUM_ROW - 1));
    last_byte  = last_phase && last_col && last_row;
    nxt_phase  = 1'b0;
    nxt_col    = col_cnt;
    nxt_row    = row_cnt;
    nxt_idx    = pix_idx;
    if (WIDE && !phase) begin
      nxt_phase = 1'b1;
    end else begin
      nxt_idx = pix_idx + IDX_W'(1);
      if (last_col) begin
        nxt_col = '0;
        nxt_row = row_cnt + ROW_W'(1);
      end else begin
        nxt_col = col_cnt + COL_W'(1);
      end
    end
    nxt_byte = pixel_byte(pix_snap[nxt_idx], text_snap, bg_snap, ~nxt_phase);
  end

  // Frame snapshot: data-only registers, loaded once per accepted start.
  always_ff @(posedge i_CLK) begin
    if (state == S_IDLE && i_START) begin
      pix_snap  <= i_PIXEL;
      text_snap <= i_TEXT_COLOR;
      bg_snap   <= i_BACKGROUND_COLOR;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= S_IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      pix_idx <= '0;
      phase   <= 1'b0;
`ifdef OLED_STREAM_WINDOW_EN
      cmd_cnt <= '0;
`endif
      o_VALID <= 1'b0;
      o_DONE  <= 1'b0;
      o_READY <= 1'b1;
      o_DC    <= 1'b0;
      o_DATA  <= 8'h00;
    end else begin
      o_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_START) begin
            col_cnt <= '0;
            row_cnt <= '0;
            pix_idx <= '0;
            phase   <= 1'b0;
            o_READY <= 1'b0;
            o_VALID <= 1'b1;
`ifdef OLED_STREAM_WINDOW_EN
            cmd_cnt <= '0;
            state   <= S_CMD;
            o_DC    <= 1'b0;
            o_DATA  <= cmd_byte(3'd0);
`else
            // Snapshot lands on this same edge, so the first byte comes from the live inputs.
            state   <= S_PIXEL;
            o_DC    <= 1'b1;
            o_DATA  <= pixel_byte(i_PIXEL[0], i_TEXT_COLOR, i_BACKGROUND_COLOR, 1'b1);
`endif
          end
        end
`ifdef OLED_STREAM_WINDOW_EN
        S_CMD: begin
          if (i_ACK) begin
            if (cmd_cnt == 3'd5) begin
              state  <= S_PIXEL;
              o_DC   <= 1'b1;
              o_DATA <= pixel_byte(pix_snap[0], text_snap, bg_snap, 1'b1);
            end else begin
              cmd_cnt <= cmd_cnt + 3'd1;
              o_DATA  <= cmd_byte(cmd_cnt + 3'd1);
            end
          end
        end
`endif
        S_PIXEL: begin
          if (i_ACK) begin
            if (last_byte) begin
              state   <= S_DONE;
              o_VALID <= 1'b0;
              o_DONE  <= 1'b1;
            end else begin
              col_cnt <= nxt_col;
              row_cnt <= nxt_row;
              pix_idx <= nxt_idx;
              phase   <= nxt_phase;
              o_DATA  <= nxt_byte;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          o_READY <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          o_VALID <= 1'b0;
          o_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule
